// File: rtl/mips_seq_pkg.sv
// Shared types and encodings for the multi-cycle MIPS step sequencer.
package mips_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MD_WAIT   = 3'd4,
    ST_MEM       = 3'd5,
    ST_WRITEBACK = 3'd6,
    ST_FAULT     = 3'd7
  } state_t;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned FUNC_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [FUNC_W-1:0] FUNC_MULT  = 6'h18;
  localparam logic [FUNC_W-1:0] FUNC_MULTU = 6'h19;
  localparam logic [FUNC_W-1:0] FUNC_DIV   = 6'h1A;
  localparam logic [FUNC_W-1:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } branch_t;

  typedef enum logic [1:0] {
    PCSEL_PC4    = 2'b00,
    PCSEL_BRANCH = 2'b01,
    PCSEL_JUMP   = 2'b10
  } pcsel_t;

  // R-type mult/multu/div/divu are handed off to the mult/div unit
  function automatic logic is_muldiv(input logic [OP_W-1:0] op, input logic [FUNC_W-1:0] fn);
    return (op == OP_RTYPE) &&
           ((fn == FUNC_MULT) || (fn == FUNC_MULTU) || (fn == FUNC_DIV) || (fn == FUNC_DIVU));
  endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Wait-cycle counter: cleared while idle, counts while enabled, saturates at LIMIT-1.
module seq_wait_timer #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic at_start,
  output logic at_limit
);

  localparam int unsigned CNT_W = $clog2(LIMIT) + 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + CNT_W'(1);
    end
  end

  assign at_start = (count == '0);
  // at_limit marks the last permitted wait cycle
  assign at_limit = (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle step sequencer: gates controller enables into one phase at a time,
// stalls on data memory and mult/div, counts retirements, traps hangs in FAULT.
module multicycle_sequencer
  import mips_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned MD_TIMEOUT  = 40,
  parameter int unsigned COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               ctrlRegWrite,
  input  logic               ctrlMemRead,
  input  logic               ctrlMemWrite,
  input  logic               ctrlJump,
  input  logic [1:0]         ctrlBranch,
  input  logic               isAluOutputZero,
  input  logic               memReady,
  input  logic               mdBusy,
  output logic               irWrite,
  output logic               pcWrite,
  output logic [1:0]         pcSel,
  output logic               regWriteEn,
  output logic               memReadEn,
  output logic               memWriteEn,
  output logic               mdStart,
  output logic               busy,
  output logic               fault,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] retiredCount
);

  state_t cur_state;
  state_t nxt_state;
  state_t issue_state;

  logic   ir_write_c;
  logic   pc_write_c;
  pcsel_t pc_sel_c;
  logic   reg_write_c;
  logic   mem_read_c;
  logic   mem_write_c;
  logic   md_start_c;
  logic   is_branch_c;
  logic   taken_c;

  logic   mem_start;
  logic   mem_limit;
  logic   md_first;
  logic   md_limit;

  logic [COUNT_W-1:0] retired_q;

  seq_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_mem_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (cur_state != ST_MEM),
    .en       (cur_state == ST_MEM),
    .at_start (mem_start),
    .at_limit (mem_limit)
  );

  seq_wait_timer #(.LIMIT(MD_TIMEOUT)) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (cur_state != ST_MD_WAIT),
    .en       (cur_state == ST_MD_WAIT),
    .at_start (md_first),
    .at_limit (md_limit)
  );

  // Where a retiring instruction goes next
  assign issue_state = run ? ST_FETCH : ST_IDLE;
  assign is_branch_c = (ctrlBranch == BR_BEQ) || (ctrlBranch == BR_BNE);
  assign taken_c     = ((ctrlBranch == BR_BEQ) &&  isAluOutputZero) ||
                       ((ctrlBranch == BR_BNE) && !isAluOutputZero);

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_state <= ST_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_sel_c    = PCSEL_PC4;
    reg_write_c = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    md_start_c  = 1'b0;
    case (cur_state)
      ST_IDLE: begin
        if (run) nxt_state = ST_FETCH;
      end
      ST_FETCH: begin
        ir_write_c = 1'b1;
        nxt_state  = ST_DECODE;
      end
      ST_DECODE: begin
        if (ctrlJump) begin
          pc_write_c = 1'b1;
          pc_sel_c   = PCSEL_JUMP;
          nxt_state  = issue_state;
        end else if (is_muldiv(opcode, func)) begin
          md_start_c = 1'b1;
          nxt_state  = ST_MD_WAIT;
        end else begin
          nxt_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (is_branch_c) begin
          pc_write_c = 1'b1;
          pc_sel_c   = taken_c ? PCSEL_BRANCH : PCSEL_PC4;
          nxt_state  = issue_state;
        end else if (ctrlMemRead || ctrlMemWrite) begin
          nxt_state = ST_MEM;
        end else if (ctrlRegWrite) begin
          nxt_state = ST_WRITEBACK;
        end else begin
          pc_write_c = 1'b1;
          nxt_state  = issue_state;
        end
      end
      ST_MEM: begin
        mem_read_c  = ctrlMemRead;
        mem_write_c = ctrlMemWrite;
        if (memReady) begin
          if (ctrlMemRead) begin
            nxt_state = ST_WRITEBACK;
          end else begin
            pc_write_c = 1'b1;
            nxt_state  = issue_state;
          end
        end else if (mem_limit) begin
          nxt_state = ST_FAULT;
        end
      end
      ST_MD_WAIT: begin
        // mdBusy is not yet valid on the cycle right after mdStart
        if (!md_first) begin
          if (!mdBusy) begin
            pc_write_c = 1'b1;
            nxt_state  = issue_state;
          end else if (md_limit) begin
            nxt_state = ST_FAULT;
          end
        end
      end
      ST_WRITEBACK: begin
        reg_write_c = 1'b1;
        pc_write_c  = 1'b1;
        nxt_state   = issue_state;
      end
      ST_FAULT: begin
        nxt_state = ST_FAULT;
      end
      default: begin
        nxt_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retired_q <= '0;
    end else if (pc_write_c) begin
      retired_q <= retired_q + COUNT_W'(1);
    end
  end

  // Every output is held low while reset is asserted
  assign irWrite      = ir_write_c  & ~reset;
  assign pcWrite      = pc_write_c  & ~reset;
  assign pcSel        = reset ? 2'b00 : pc_sel_c;
  assign regWriteEn   = reg_write_c & ~reset;
  assign memReadEn    = mem_read_c  & ~reset;
  assign memWriteEn   = mem_write_c & ~reset;
  assign mdStart      = md_start_c  & ~reset;
  assign busy         = ~reset & (cur_state != ST_IDLE) & (cur_state != ST_FAULT);
  assign fault        = ~reset & (cur_state == ST_FAULT);
  assign state        = reset ? 3'd0 : cur_state;
  assign retiredCount = reset ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized scoreboard bench for multicycle_sequencer with directed hang/reset/run-drop cases.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        ctrlRegWrite, ctrlMemRead, ctrlMemWrite, ctrlJump;
  logic [1:0]  ctrlBranch;
  logic        isAluOutputZero, memReady, mdBusy;
  logic        irWrite, pcWrite, regWriteEn, memReadEn, memWriteEn, mdStart, busy, fault;
  logic [1:0]  pcSel;
  logic [2:0]  state;
  logic [31:0] retiredCount;

  multicycle_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .func(func),
    .ctrlRegWrite(ctrlRegWrite), .ctrlMemRead(ctrlMemRead), .ctrlMemWrite(ctrlMemWrite),
    .ctrlJump(ctrlJump), .ctrlBranch(ctrlBranch), .isAluOutputZero(isAluOutputZero),
    .memReady(memReady), .mdBusy(mdBusy), .irWrite(irWrite), .pcWrite(pcWrite),
    .pcSel(pcSel), .regWriteEn(regWriteEn), .memReadEn(memReadEn), .memWriteEn(memWriteEn),
    .mdStart(mdStart), .busy(busy), .fault(fault), .state(state), .retiredCount(retiredCount)
  );

  always #5 clk = ~clk;

  localparam int K_J = 0, K_BEQ = 1, K_BNE = 2, K_NOP = 3, K_ALU = 4, K_LW = 5, K_SW = 6, K_MD = 7;

  typedef struct {
    int         lat;
    logic [1:0] sel;
    bit         reg_wr;
    int         rd_cycles;
    int         wr_cycles;
    int         md_starts;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   retired_model = 0;
  bit   sb_on = 0;
  int   fetch_cyc = 0, rd_cnt = 0, wr_cnt = 0, md_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic finish_bench();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  endtask

  // Reference: cycle cost and visible effects of one instruction
  function automatic exp_t model(input int kind, input bit zero, input int n, input int m);
    exp_t e;
    e = '{lat: 3, sel: 2'b00, reg_wr: 0, rd_cycles: 0, wr_cycles: 0, md_starts: 0, idx: 0};
    case (kind)
      K_J:   begin e.lat = 2; e.sel = 2'b10; end
      K_BEQ: e.sel = zero ? 2'b01 : 2'b00;
      K_BNE: e.sel = zero ? 2'b00 : 2'b01;
      K_ALU: begin e.lat = 4; e.reg_wr = 1; end
      K_LW:  begin e.lat = 4 + n; e.reg_wr = 1; e.rd_cycles = n; end
      K_SW:  begin e.lat = 3 + n; e.wr_cycles = n; end
      K_MD:  begin e.lat = 3 + m; e.md_starts = 1; end
      default: ;
    endcase
    return e;
  endfunction

  task automatic set_ctrl(input int kind, input bit zero);
    int v;
    opcode = 6'h00; func = 6'h00; ctrlRegWrite = 0; ctrlMemRead = 0; ctrlMemWrite = 0;
    ctrlJump = 0; ctrlBranch = 2'b00; isAluOutputZero = zero;
    memReady = 1'($urandom_range(0, 1));
    case (kind)
      K_J:   begin opcode = 6'h02; ctrlJump = 1; end
      K_BEQ: begin opcode = 6'h04; ctrlBranch = 2'b01; end
      K_BNE: begin opcode = 6'h05; ctrlBranch = 2'b10; end
      K_ALU: begin
        v = $urandom_range(0, 2);
        ctrlRegWrite = 1;
        if (v == 0) opcode = 6'h08;
        else if (v == 1) func = 6'h20;
        else begin opcode = 6'h08; ctrlBranch = 2'b11; end
      end
      K_LW:  begin opcode = 6'h23; ctrlMemRead = 1; ctrlRegWrite = 1; end
      K_SW:  begin opcode = 6'h2B; ctrlMemWrite = 1; end
      K_MD:  func = 6'(6'h18 + $urandom_range(0, 3));
      default: ;
    endcase
  endtask

  task automatic run_instr(input int kind, input bit zero, input int n, input int m, input bit drop);
    exp_t e;
    int   t = 0;
    @(negedge clk);
    while (!irWrite) begin
      if (t == 20) begin
        checks++;
        $display("FAIL fetch_timeout: irWrite not seen within 20 cycles");
        finish_bench();
      end
      @(negedge clk);
      t++;
    end
    set_ctrl(kind, zero);
    e = model(kind, zero, n, m);
    e.idx = retired_model;
    retired_model++;
    exp_q.push_back(e);
    for (int k = 2; k <= e.lat; k++) begin
      @(posedge clk); #1;
      if ((kind == K_LW || kind == K_SW) && k >= 4) memReady = (k == 3 + n);
      else memReady = 1'($urandom_range(0, 1));
      mdBusy = (kind == K_MD) && (k >= 3) && (k <= 2 + m);
      if (drop && k == 3) run = 0;
    end
    @(posedge clk); #1;
    memReady = 0;
    mdBusy = 0;
  endtask

  task automatic hang_test(input bit is_md, input int exp_wait, input logic [2:0] wait_st);
    int waits = 0;
    int t = 0;
    set_ctrl(is_md ? K_MD : K_LW, 0);
    memReady = 0;
    mdBusy = is_md;
    run = 1;
    while (state != 3'd7 && t < 100) begin
      @(negedge clk);
      t++;
      if (state == wait_st) waits++;
    end
    check("hang_reaches_fault", state, 3'd7);
    check("hang_wait_cycles", waits, exp_wait);
    check("fault_flag", fault, 1'b1);
    check("fault_enables_off", {busy, memReadEn, pcWrite, mdStart, irWrite}, 5'b0);
    repeat (5) begin @(posedge clk); #1; memReady = 1; mdBusy = 0; run = ~run; end
    @(negedge clk);
    check("fault_sticky", {fault, state}, {1'b1, 3'd7});
    memReady = 0;
    reset = 1;
    #1;
    check("fault_cleared_in_reset", {fault, state}, 4'b0);
    @(posedge clk); #1;
    reset = 0;
    run = 0;
    @(negedge clk);
    check("after_fault_reset_state", state, 3'd0);
    check("after_fault_reset_count", retiredCount, 32'd0);
  endtask

  // Scoreboard monitor: pops one expectation per retirement
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sb_on) begin
      exp_t e;
      if (irWrite) begin fetch_cyc = cyc; rd_cnt = 0; wr_cnt = 0; md_cnt = 0; end
      if (memReadEn) rd_cnt++;
      if (memWriteEn) wr_cnt++;
      if (mdStart) md_cnt++;
      if (regWriteEn && !pcWrite) begin
        checks++;
        $display("FAIL stray_regwrite: regWriteEn=1 without pcWrite at cycle %0d", cyc);
      end
      if (pcWrite) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_retire: pcWrite with empty scoreboard at cycle %0d", cyc);
        end else begin
          e = exp_q.pop_front();
          check("latency", cyc - fetch_cyc + 1, e.lat);
          check("pcsel", pcSel, e.sel);
          check("regwrite", regWriteEn, e.reg_wr);
          check("memread_cycles", rd_cnt, e.rd_cycles);
          check("memwrite_cycles", wr_cnt, e.wr_cycles);
          check("mdstart_pulses", md_cnt, e.md_starts);
          check("retired_count", retiredCount, e.idx);
          check("busy_on_retire", busy, 1'b1);
        end
      end
    end
  end

  initial begin
    #600000;
    checks++;
    $display("FAIL watchdog: simulation did not finish in time");
    finish_bench();
  end

  initial begin
    int kind;
    reset = 1; run = 1; memReady = 1; mdBusy = 1;
    set_ctrl(K_ALU, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {irWrite, pcWrite, pcSel, regWriteEn, memReadEn, memWriteEn,
                            mdStart, busy, fault, state}, 14'b0);
    check("reset_retired", retiredCount, 32'd0);
    @(posedge clk); #1;
    reset = 0; memReady = 0; mdBusy = 0;
    #1;
    check("idle_after_reset", {busy, state}, 4'b0);

    sb_on = 1;
    run_instr(K_ALU, 0, 0, 0, 0);
    run_instr(K_BEQ, 1, 0, 0, 0);
    run_instr(K_BEQ, 0, 0, 0, 0);
    run_instr(K_BNE, 0, 0, 0, 0);
    run_instr(K_J,   0, 0, 0, 0);
    run_instr(K_LW,  0, 6, 0, 0);
    run_instr(K_SW,  0, 6, 0, 0);
    run_instr(K_MD,  0, 0, 10, 0);
    run_instr(K_LW,  0, 16, 0, 0);
    run_instr(K_MD,  0, 0, 39, 0);
    run_instr(K_NOP, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 7);
      run_instr(kind, 1'($urandom_range(0, 1)), $urandom_range(1, 16), $urandom_range(1, 39), 0);
    end
    run_instr(K_ALU, 0, 0, 0, 1);
    sb_on = 0;
    check("scoreboard_drained", exp_q.size(), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("idle_after_run_drop", {irWrite, busy, state}, 5'b0);
    end
    check("final_retired_count", retiredCount, retired_model);

    hang_test(0, 16, 3'd5);

    set_ctrl(K_LW, 0);
    memReady = 0;
    run = 1;
    for (int t = 0; t < 20 && state != 3'd5; t++) @(negedge clk);
    @(negedge clk);
    check("in_mem_before_reset", {state, memReadEn}, {3'd5, 1'b1});
    reset = 1;
    #1;
    check("outputs_zero_in_reset", {irWrite, pcWrite, pcSel, regWriteEn, memReadEn, memWriteEn,
                                    mdStart, busy, fault, state}, 14'b0);
    @(posedge clk); #1;
    reset = 0;
    run = 0;
    @(negedge clk);
    check("idle_after_mem_reset", {busy, memReadEn, state}, 5'b0);

    hang_test(1, 40, 3'd4);
    finish_bench();
  end

endmodule
